spinner_array: RTL and testbench

Multi-channel rotary/positional input emulator between the input-mapping logic and the core's input ports in each arcade top level. It replaces the per-game single-channel spinner instances with one parametrised block: N independent channels, configurable position width, button-driven motion with hold acceleration, a direct spinner-pulse mode, and per-channel wrap or clamp. Each channel outputs a position word that is sliced directly into the core's input bytes.

---
 rtl/spinner_pkg.sv | 49 ++++
 rtl/spinner_array_channel.sv | 121 ++++++++++++
 rtl/spinner_array.sv | 64 ++++++
 tb/tb_spinner_array.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spinner_pkg.sv
// Shared types, default parameters and the saturating/wrapping adder used
// by every spinner channel.
package spinner_pkg;

    typedef enum logic {
        MODE_BUTTON  = 1'b0,
        MODE_SPINNER = 1'b1
    } spin_mode_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } spin_dir_e;

    localparam int DEF_CHANNELS     = 2;
    localparam int DEF_WIDTH        = 8;
    localparam int DEF_STEP         = 4;
    localparam int DEF_ACCEL_FRAMES = 8;
    localparam int DEF_ACCEL_MAX    = 4;
    localparam int DEF_INIT         = 0;

    localparam int MAX_WIDTH = 16;
    localparam int ARITH_W   = MAX_WIDTH + 2;

    // Adds a signed delta to an unsigned position of 'width' bits, then either
    // saturates to [0, 2^width-1] or keeps the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] sat_wrap_add(
        input logic        [MAX_WIDTH-1:0] pos,
        input logic signed [ARITH_W-1:0]   delta,
        input int                          width,
        input logic                        clamp
    );
        logic signed [ARITH_W-1:0] sum;
        logic signed [ARITH_W-1:0] lim;
        sum = $signed({2'b00, pos}) + delta;
        lim = $signed(ARITH_W'((1 << width) - 1));
        if (clamp) begin
            if (sum < 0)
                sum = '0;
            else if (sum > lim)
                sum = lim;
        end else begin
            sum = sum & lim;
        end
        return sum[MAX_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/spinner_array_channel.sv
// One spinner channel: input edge detection, hold-acceleration state and
// the position register with its change pulse.
module spinner_array_channel
    import spinner_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int STEP         = DEF_STEP,
    parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
    parameter int ACCEL_MAX    = DEF_ACCEL_MAX,
    parameter int INIT         = DEF_INIT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             strobe_edge,
    input  logic             plus,
    input  logic             minus,
    input  logic             use_spinner,
    input  logic             clamp,
    output logic [WIDTH-1:0] angle,
    output logic             changed
);

    localparam int MW = $clog2(ACCEL_MAX + 1);
    localparam int HW = $clog2(ACCEL_FRAMES + 1);

    logic              plus_d_reg, minus_d_reg, spin_d_reg;
    logic [MW-1:0]     mult_reg, mult_next, mult_eff;
    logic [HW-1:0]     hold_reg, hold_next, hold_eff;
    spin_dir_e         dir_reg, dir_next, dir_eff, dir_cur;
    logic [WIDTH-1:0]  pos_reg, pos_next;
    logic              changed_reg;
    logic signed [ARITH_W-1:0] delta;
    logic [ARITH_W-1:0] mag;
    logic              plus_rise, minus_rise;
    spin_mode_e        mode;

    assign mode       = spin_mode_e'(use_spinner);
    assign plus_rise  = plus & ~plus_d_reg;
    assign minus_rise = minus & ~minus_d_reg;

    always_comb begin
        mult_next = mult_reg;
        hold_next = hold_reg;
        dir_next  = dir_reg;
        mult_eff  = mult_reg;
        hold_eff  = hold_reg;
        dir_eff   = dir_reg;
        dir_cur   = DIR_NONE;
        delta     = '0;
        mag       = '0;
        if (mode == MODE_SPINNER) begin
            mult_next = MW'(1);
            hold_next = '0;
            dir_next  = DIR_NONE;
            if (plus_rise && !minus_rise)
                delta = ARITH_W'(1);
            else if (minus_rise && !plus_rise)
                delta = '1;
        end else begin
            // Coming back from spinner mode restarts acceleration.
            if (spin_d_reg) begin
                mult_eff = MW'(1);
                hold_eff = '0;
                dir_eff  = DIR_NONE;
            end
            mult_next = mult_eff;
            hold_next = hold_eff;
            dir_next  = dir_eff;
            if (strobe_edge) begin
                if (plus ^ minus) begin
                    dir_cur = plus ? DIR_UP : DIR_DOWN;
                    if (dir_eff != DIR_NONE && dir_eff != dir_cur) begin
                        mult_eff = MW'(1);
                        hold_eff = '0;
                    end
                    mag   = ARITH_W'(STEP) * ARITH_W'(mult_eff);
                    delta = (dir_cur == DIR_UP) ? $signed(mag) : -$signed(mag);
                    if (hold_eff == HW'(ACCEL_FRAMES - 1)) begin
                        hold_next = '0;
                        mult_next = (mult_eff < MW'(ACCEL_MAX)) ? mult_eff + 1'b1 : MW'(ACCEL_MAX);
                    end else begin
                        hold_next = hold_eff + 1'b1;
                        mult_next = mult_eff;
                    end
                    dir_next = dir_cur;
                end else begin
                    mult_next = MW'(1);
                    hold_next = '0;
                    dir_next  = DIR_NONE;
                end
            end
        end
        pos_next = WIDTH'(sat_wrap_add(MAX_WIDTH'(pos_reg), delta, WIDTH, clamp));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plus_d_reg  <= 1'b0;
            minus_d_reg <= 1'b0;
            spin_d_reg  <= 1'b0;
            mult_reg    <= MW'(1);
            hold_reg    <= '0;
            dir_reg     <= DIR_NONE;
            pos_reg     <= WIDTH'(INIT);
            changed_reg <= 1'b0;
        end else begin
            plus_d_reg  <= plus;
            minus_d_reg <= minus;
            spin_d_reg  <= use_spinner;
            mult_reg    <= mult_next;
            hold_reg    <= hold_next;
            dir_reg     <= dir_next;
            pos_reg     <= pos_next;
            changed_reg <= (pos_next != pos_reg);
        end
    end

    assign angle   = pos_reg;
    assign changed = changed_reg;

endmodule

// File: rtl/spinner_array.sv
// N-channel rotary/positional input emulator: shared frame-strobe edge
// detector feeding independent spinner channels, packed onto one bus.
module spinner_array
    import spinner_pkg::*;
#(
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int WIDTH        = DEF_WIDTH,
    parameter int STEP         = DEF_STEP,
    parameter int ACCEL_FRAMES = DEF_ACCEL_FRAMES,
    parameter int ACCEL_MAX    = DEF_ACCEL_MAX,
    parameter int INIT         = DEF_INIT
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      strobe,
    input  logic [CHANNELS-1:0]       plus,
    input  logic [CHANNELS-1:0]       minus,
    input  logic [CHANNELS-1:0]       use_spinner,
    input  logic [CHANNELS-1:0]       clamp,
    output logic [CHANNELS*WIDTH-1:0] angle,
    output logic [CHANNELS-1:0]       changed
);

    if (CHANNELS < 1 || CHANNELS > 8 || WIDTH < 4 || WIDTH > MAX_WIDTH ||
        STEP * ACCEL_MAX >= (1 << WIDTH)) begin : g_bad_params
        $error("spinner_array: parameter out of range");
    end

    logic strobe_d_reg;
    logic strobe_edge;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            strobe_d_reg <= 1'b0;
        else
            strobe_d_reg <= strobe;
    end

    assign strobe_edge = strobe & ~strobe_d_reg;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            spinner_array_channel #(
                .WIDTH        (WIDTH),
                .STEP         (STEP),
                .ACCEL_FRAMES (ACCEL_FRAMES),
                .ACCEL_MAX    (ACCEL_MAX),
                .INIT         (INIT)
            ) u_chan (
                .clk         (clk),
                .reset_n     (reset_n),
                .strobe_edge (strobe_edge),
                .plus        (plus[gi]),
                .minus       (minus[gi]),
                .use_spinner (use_spinner[gi]),
                .clamp       (clamp[gi]),
                .angle       (angle[gi*WIDTH +: WIDTH]),
                .changed     (changed[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_spinner_array.sv
// Directed and random stimulus for spinner_array, checked against a
// behavioural integer model of the channel rules.
module tb_spinner_array;

    localparam int CH = 2;
    localparam int W  = 8;
    localparam int STEP = 4;
    localparam int FRAMES = 8;
    localparam int AMAX = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          strobe = 1'b0;
    logic [CH-1:0] plus = '0, minus = '0, use_spinner = '0, clamp = '0;
    logic [CH*W-1:0] angle;
    logic [CH-1:0] changed;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_pos[CH], m_mult[CH], m_hold[CH], m_dir[CH];
    bit m_changed[CH], m_plus_p[CH], m_minus_p[CH], m_spin_p[CH];
    bit m_strobe_p;

    spinner_array #(
        .CHANNELS(CH), .WIDTH(W), .STEP(STEP), .ACCEL_FRAMES(FRAMES),
        .ACCEL_MAX(AMAX), .INIT(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .plus(plus),
        .minus(minus), .use_spinner(use_spinner), .clamp(clamp),
        .angle(angle), .changed(changed)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_pos[c] = 0; m_mult[c] = 1; m_hold[c] = 0; m_dir[c] = 0;
            m_changed[c] = 0; m_plus_p[c] = 0; m_minus_p[c] = 0; m_spin_p[c] = 0;
        end
        m_strobe_p = 0;
    endtask

    task automatic model_clock();
        bit se;
        int d, nv, dir;
        if (!reset_n) return;
        se = strobe && !m_strobe_p;
        for (int c = 0; c < CH; c++) begin
            d = 0;
            if (use_spinner[c]) begin
                m_mult[c] = 1; m_hold[c] = 0; m_dir[c] = 0;
                if (plus[c] && !m_plus_p[c]) d += 1;
                if (minus[c] && !m_minus_p[c]) d -= 1;
            end else begin
                if (m_spin_p[c]) begin
                    m_mult[c] = 1; m_hold[c] = 0; m_dir[c] = 0;
                end
                if (se) begin
                    if (plus[c] != minus[c]) begin
                        dir = plus[c] ? 1 : -1;
                        if (m_dir[c] != 0 && m_dir[c] != dir) begin
                            m_mult[c] = 1; m_hold[c] = 0;
                        end
                        d = dir * STEP * m_mult[c];
                        m_hold[c]++;
                        if (m_hold[c] == FRAMES) begin
                            m_hold[c] = 0;
                            m_mult[c] = (m_mult[c] + 1 > AMAX) ? AMAX : m_mult[c] + 1;
                        end
                        m_dir[c] = dir;
                    end else begin
                        m_mult[c] = 1; m_hold[c] = 0; m_dir[c] = 0;
                    end
                end
            end
            nv = m_pos[c] + d;
            if (clamp[c]) begin
                if (nv < 0) nv = 0;
                if (nv > (1 << W) - 1) nv = (1 << W) - 1;
            end else begin
                nv = ((nv % (1 << W)) + (1 << W)) % (1 << W);
            end
            m_changed[c] = (nv != m_pos[c]);
            m_pos[c] = nv;
            m_plus_p[c] = plus[c];
            m_minus_p[c] = minus[c];
            m_spin_p[c] = use_spinner[c];
        end
        m_strobe_p = strobe;
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] a;
        for (int c = 0; c < CH; c++) begin
            a = angle[c*W +: W];
            vectors++;
            assert (a === W'(m_pos[c])) else begin
                miscompares++;
                $error("FAIL %s angle ch%0d observed %0d expected %0d", tag, c, a, m_pos[c]);
            end
            vectors++;
            assert (changed[c] === m_changed[c]) else begin
                miscompares++;
                $error("FAIL %s changed ch%0d observed %0b expected %0b", tag, c, changed[c], m_changed[c]);
            end
        end
    endtask

    task automatic check_val(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic strobe_pulse(input string tag);
        strobe = 1'b1;
        tick(tag);
        strobe = 1'b0;
        tick(tag);
    endtask

    task automatic do_reset();
        strobe = 0; plus = '0; minus = '0; use_spinner = '0; clamp = '0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic int ang(input int c);
        logic [CH*W-1:0] v;
        v = angle;
        return int'(v[c*W +: W]);
    endfunction

    initial begin
        model_reset();

        // Reset state, then release with strobe already high
        #2;
        check_all("reset_hold");
        strobe = 1'b1; plus = 2'b01;
        @(negedge clk);
        reset_n = 1'b1;
        tick("release");
        check_val("release_edge", ang(0), 4);
        strobe = 1'b0;
        tick("release");

        // Acceleration with wrap
        do_reset();
        plus = 2'b01;
        for (int s = 1; s <= 33; s++) begin
            strobe_pulse("accel");
            if (s == 8)  check_val("accel_8", ang(0), 32);
            if (s == 16) check_val("accel_16", ang(0), 96);
            if (s == 24) check_val("accel_24", ang(0), 192);
            if (s == 32) check_val("accel_32", ang(0), 64);
            if (s == 33) check_val("accel_33", ang(0), 80);
        end

        // Clamp at zero, then wrap below zero
        do_reset();
        clamp = 2'b01; minus = 2'b01;
        for (int s = 0; s < 5; s++) strobe_pulse("clamp");
        check_val("clamp_zero", ang(0), 0);
        clamp = 2'b00;
        strobe_pulse("wrap");
        check_val("wrap_252", ang(0), 252);

        // Spinner pulses on ch1
        do_reset();
        use_spinner = 2'b10;
        tick("spin");
        for (int p = 0; p < 3; p++) begin
            plus = 2'b10;
            tick("spin");
            check_val("spin_pulse", int'(changed[1]), 1);
            plus = 2'b00;
            tick("spin");
        end
        check_val("spin_3", ang(1), 3);
        plus = 2'b10; minus = 2'b10;
        tick("spin_both");
        check_val("spin_both_pos", ang(1), 3);
        check_val("spin_both_chg", int'(changed[1]), 0);
        plus = 2'b00; minus = 2'b00;
        tick("spin");

        // Direction reversal after building mult 2
        do_reset();
        plus = 2'b01;
        for (int s = 0; s < 10; s++) strobe_pulse("rev");
        check_val("rev_48", ang(0), 48);
        plus = 2'b00; minus = 2'b01;
        strobe_pulse("rev");
        check_val("rev_44", ang(0), 44);

        // Opposite directions on the same strobe
        do_reset();
        plus = 2'b01; minus = 2'b10;
        strobe_pulse("opp");
        check_val("opp_ch0", ang(0), 4);
        check_val("opp_ch1", ang(1), 252);

        // Asynchronous reset mid-hold
        do_reset();
        plus = 2'b01;
        for (int s = 0; s < 17; s++) strobe_pulse("midhold");
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("async_reset", ang(0), 0);
        check_all("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        strobe_pulse("after_reset");
        check_val("after_reset_4", ang(0), 4);

        // Random stimulus
        do_reset();
        for (int i = 0; i < 600; i++) begin
            strobe = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) plus  = CH'($urandom);
            if ($urandom_range(0, 3) == 0) minus = CH'($urandom);
            if ($urandom_range(0, 39) == 0) use_spinner = CH'($urandom);
            if ($urandom_range(0, 29) == 0) clamp = CH'($urandom);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
